// File: rtl/sar_seq_pkg.sv
// Shared types and helpers for the SAR phase-sequence clock gate.
// Holds the state encoding, default field widths and the 0->1 length rule.
package sar_seq_pkg;

  localparam int DEF_T_W   = 4;
  localparam int DEF_CYC_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SAMP,
    COMP,
    UPD,
    DONE
  } state_t;

  // A programmed length of zero behaves exactly like a length of one.
  function automatic int unsigned eff_len(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter with a zero flag, shared by every phase of the sequence.
// It holds at zero until the next load.
module sar_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sar_seqgate.sv
// SAR conversion sequencer driving flop-based, glitch-free gated phase strobes.
// Config and enables are captured once per conversion at the shadow point.
module sar_seqgate
  import sar_seq_pkg::*;
#(
  parameter int T_W   = DEF_T_W,
  parameter int N_CH  = 1,
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic [T_W-1:0]   cfg_t_init,
  input  logic [T_W-1:0]   cfg_t_samp,
  input  logic [T_W-1:0]   cfg_t_comp,
  input  logic [T_W-1:0]   cfg_t_upd,
  input  logic [CYC_W-1:0] cfg_n_cyc,
  input  logic             en_init,
  input  logic             en_comp,
  input  logic [N_CH-1:0]  en_samp_p,
  input  logic [N_CH-1:0]  en_samp_n,
  input  logic [N_CH-1:0]  en_update_p,
  input  logic [N_CH-1:0]  en_update_n,
  output logic             clk_init,
  output logic             clk_comp,
  output logic [N_CH-1:0]  clk_samp_p,
  output logic [N_CH-1:0]  clk_samp_n,
  output logic [N_CH-1:0]  clk_update_p,
  output logic [N_CH-1:0]  clk_update_n,
  output logic [CYC_W-1:0] cyc_idx,
  output logic             busy,
  output logic             done
);

  state_t state, next_state;
  logic   shadow;
  logic   cont_q;
  logic   timer_zero;
  logic   timer_load;
  logic [T_W-1:0] load_len;
  logic [T_W-1:0] timer_val;

  // INIT is only ever entered at a shadow edge, so its length and the cycle
  // count are taken straight from the inputs and need no shadow copy.
  logic [T_W-1:0] sh_t_samp, sh_t_comp, sh_t_upd;
  logic           sh_en_init, sh_en_comp;
  logic [N_CH-1:0] sh_samp_p, sh_samp_n, sh_upd_p, sh_upd_n;

  logic            cur_en_init, cur_en_comp;
  logic [N_CH-1:0] cur_samp_p, cur_samp_n, cur_upd_p, cur_upd_n;
  logic [N_CH-1:0] gate_samp_p, gate_samp_n, gate_upd_p, gate_upd_n;

  always_comb begin
    next_state = state;
    shadow     = 1'b0;
    case (state)
      IDLE: if (start) begin
        next_state = INIT;
        shadow     = 1'b1;
      end
      INIT: if (timer_zero) next_state = SAMP;
      SAMP: if (timer_zero) next_state = COMP;
      COMP: if (timer_zero) next_state = UPD;
      UPD:  if (timer_zero) next_state = (cyc_idx == '0) ? DONE : COMP;
      DONE: begin
        if (cont_q && !stop) begin
          next_state = INIT;
          shadow     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The timer is reloaded on every state change with the new phase's length.
  always_comb begin
    load_len = '0;
    case (next_state)
      INIT:    load_len = cfg_t_init;
      SAMP:    load_len = sh_t_samp;
      COMP:    load_len = sh_t_comp;
      UPD:     load_len = sh_t_upd;
      default: load_len = '0;
    endcase
  end

  assign timer_load = (next_state != state);
  assign timer_val  = T_W'(eff_len(32'(load_len)) - 1);

  sar_phase_timer #(.W(T_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // On the shadow edge the strobe for INIT must already see the new enables.
  assign cur_en_init = shadow ? en_init     : sh_en_init;
  assign cur_en_comp = shadow ? en_comp     : sh_en_comp;
  assign cur_samp_p  = shadow ? en_samp_p   : sh_samp_p;
  assign cur_samp_n  = shadow ? en_samp_n   : sh_samp_n;
  assign cur_upd_p   = shadow ? en_update_p : sh_upd_p;
  assign cur_upd_n   = shadow ? en_update_n : sh_upd_n;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign gate_samp_p[g] = (next_state == SAMP) & cur_samp_p[g];
    assign gate_samp_n[g] = (next_state == SAMP) & cur_samp_n[g];
    assign gate_upd_p[g]  = (next_state == UPD)  & cur_upd_p[g];
    assign gate_upd_n[g]  = (next_state == UPD)  & cur_upd_n[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cont_q       <= 1'b0;
      cyc_idx      <= '0;
      sh_t_samp    <= '0;
      sh_t_comp    <= '0;
      sh_t_upd     <= '0;
      sh_en_init   <= 1'b0;
      sh_en_comp   <= 1'b0;
      sh_samp_p    <= '0;
      sh_samp_n    <= '0;
      sh_upd_p     <= '0;
      sh_upd_n     <= '0;
      clk_init     <= 1'b0;
      clk_comp     <= 1'b0;
      clk_samp_p   <= '0;
      clk_samp_n   <= '0;
      clk_update_p <= '0;
      clk_update_n <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= next_state;
      if (shadow) begin
        cont_q     <= cont & ~stop;
        cyc_idx    <= CYC_W'(eff_len(32'(cfg_n_cyc)) - 1);
        sh_t_samp  <= cfg_t_samp;
        sh_t_comp  <= cfg_t_comp;
        sh_t_upd   <= cfg_t_upd;
        sh_en_init <= en_init;
        sh_en_comp <= en_comp;
        sh_samp_p  <= en_samp_p;
        sh_samp_n  <= en_samp_n;
        sh_upd_p   <= en_update_p;
        sh_upd_n   <= en_update_n;
      end else begin
        if (stop) cont_q <= 1'b0;
        if (state == UPD && next_state == COMP) cyc_idx <= cyc_idx - 1'b1;
      end
      clk_init     <= (next_state == INIT) & cur_en_init;
      clk_comp     <= (next_state == COMP) & cur_en_comp;
      clk_samp_p   <= gate_samp_p;
      clk_samp_n   <= gate_samp_n;
      clk_update_p <= gate_upd_p;
      clk_update_n <= gate_upd_n;
      busy         <= (next_state != IDLE);
      done         <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_sar_seqgate.sv
// Randomised self-checking bench for sar_seqgate against a schedule-queue model.
// The model expands each conversion into its per-cycle phase list at the shadow point.
module tb_sar_seqgate;

  localparam int T_W   = 4;
  localparam int N_CH  = 2;
  localparam int CYC_W = 4;

  localparam int P_IDLE = 0;
  localparam int P_INIT = 1;
  localparam int P_SAMP = 2;
  localparam int P_COMP = 3;
  localparam int P_UPD  = 4;
  localparam int P_DONE = 5;

  logic clk = 1'b0;
  logic rst, start, cont, stop;
  logic [T_W-1:0]   cfg_t_init, cfg_t_samp, cfg_t_comp, cfg_t_upd;
  logic [CYC_W-1:0] cfg_n_cyc;
  logic en_init, en_comp;
  logic [N_CH-1:0] en_samp_p, en_samp_n, en_update_p, en_update_n;
  logic clk_init, clk_comp;
  logic [N_CH-1:0] clk_samp_p, clk_samp_n, clk_update_p, clk_update_n;
  logic [CYC_W-1:0] cyc_idx;
  logic busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ph;
    int cyc;
  } slot_t;

  slot_t sched[$];
  int    m_ph  = P_IDLE;
  int    m_cyc = 0;
  bit    m_cont = 1'b0;
  bit    m_en_init = 1'b0, m_en_comp = 1'b0;
  logic [N_CH-1:0] m_sp = '0, m_sn = '0, m_up = '0, m_un = '0;

  sar_seqgate #(.T_W(T_W), .N_CH(N_CH), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop),
    .cfg_t_init(cfg_t_init), .cfg_t_samp(cfg_t_samp), .cfg_t_comp(cfg_t_comp),
    .cfg_t_upd(cfg_t_upd), .cfg_n_cyc(cfg_n_cyc),
    .en_init(en_init), .en_comp(en_comp),
    .en_samp_p(en_samp_p), .en_samp_n(en_samp_n),
    .en_update_p(en_update_p), .en_update_n(en_update_n),
    .clk_init(clk_init), .clk_comp(clk_comp),
    .clk_samp_p(clk_samp_p), .clk_samp_n(clk_samp_n),
    .clk_update_p(clk_update_p), .clk_update_n(clk_update_n),
    .cyc_idx(cyc_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Expands one conversion into the exact sequence of cycles it should occupy.
  function automatic void buildSchedule();
    int n;
    n = eff(int'(cfg_n_cyc));
    sched.delete();
    repeat (eff(int'(cfg_t_init))) sched.push_back('{P_INIT, n - 1});
    repeat (eff(int'(cfg_t_samp))) sched.push_back('{P_SAMP, n - 1});
    for (int c = n - 1; c >= 0; c--) begin
      repeat (eff(int'(cfg_t_comp))) sched.push_back('{P_COMP, c});
      repeat (eff(int'(cfg_t_upd)))  sched.push_back('{P_UPD, c});
    end
    sched.push_back('{P_DONE, 0});
    m_en_init = en_init;
    m_en_comp = en_comp;
    m_sp = en_samp_p;
    m_sn = en_samp_n;
    m_up = en_update_p;
    m_un = en_update_n;
  endfunction

  function automatic void modelStep();
    bit sh_now;
    slot_t s;
    if (rst) begin
      m_ph = P_IDLE; m_cyc = 0; m_cont = 1'b0; sched.delete();
      m_en_init = 1'b0; m_en_comp = 1'b0;
      m_sp = '0; m_sn = '0; m_up = '0; m_un = '0;
      return;
    end
    sh_now = (m_ph == P_IDLE && start) || (m_ph == P_DONE && m_cont && !stop);
    if (sh_now) begin
      buildSchedule();
      m_cont = cont && !stop;
    end else if (stop) begin
      m_cont = 1'b0;
    end
    if (sched.size() > 0) begin
      s = sched.pop_front();
      m_ph  = s.ph;
      m_cyc = s.cyc;
    end else begin
      m_ph = P_IDLE;
    end
  endfunction

  // One clock: DUT and model both consume the current inputs, then outputs are compared.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("busy", 32'(busy), 32'(m_ph != P_IDLE));
    checkOutput("done", 32'(done), 32'(m_ph == P_DONE));
    checkOutput("cyc_idx", 32'(cyc_idx), 32'(m_cyc));
    checkOutput("clk_init", 32'(clk_init), 32'(m_ph == P_INIT && m_en_init));
    checkOutput("clk_comp", 32'(clk_comp), 32'(m_ph == P_COMP && m_en_comp));
    checkOutput("clk_samp_p", 32'(clk_samp_p), 32'((m_ph == P_SAMP) ? m_sp : '0));
    checkOutput("clk_samp_n", 32'(clk_samp_n), 32'((m_ph == P_SAMP) ? m_sn : '0));
    checkOutput("clk_update_p", 32'(clk_update_p), 32'((m_ph == P_UPD) ? m_up : '0));
    checkOutput("clk_update_n", 32'(clk_update_n), 32'((m_ph == P_UPD) ? m_un : '0));
  endtask

  task automatic setCfg(input int ti, input int ts, input int tc, input int tu, input int n);
    cfg_t_init = T_W'(ti);
    cfg_t_samp = T_W'(ts);
    cfg_t_comp = T_W'(tc);
    cfg_t_upd  = T_W'(tu);
    cfg_n_cyc  = CYC_W'(n);
  endtask

  task automatic setEnables(input logic ei, input logic ec, input logic [N_CH-1:0] sp,
                            input logic [N_CH-1:0] sn, input logic [N_CH-1:0] up,
                            input logic [N_CH-1:0] un);
    en_init = ei; en_comp = ec;
    en_samp_p = sp; en_samp_n = sn; en_update_p = up; en_update_n = un;
  endtask

  initial begin
    int cycles;
    rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0;
    setCfg(1, 2, 1, 1, 3);
    setEnables(1'b1, 1'b1, '1, '1, '1, '1);
    repeat (3) applyStimulus();
    rst = 1'b0;
    applyStimulus();

    $display("[TB] basic single-shot sequence");
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    repeat (14) applyStimulus();

    $display("[TB] partial enables, toggled mid-conversion");
    setEnables(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b10);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      setEnables(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 2'($urandom));
      setCfg(int'($urandom_range(0, 5)), 2, 1, 1, int'($urandom_range(0, 5)));
      applyStimulus();
    end

    $display("[TB] continuous mode, then stop");
    setCfg(2, 2, 1, 1, 2);
    setEnables(1'b1, 1'b1, '1, '1, '1, '1);
    cont = 1'b1; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    repeat (30) applyStimulus();
    stop = 1'b1;
    applyStimulus();
    stop = 1'b0;
    repeat (15) applyStimulus();
    cont = 1'b0;

    $display("[TB] zero-length fields");
    setCfg(0, 0, 0, 0, 0);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    repeat (8) applyStimulus();

    $display("[TB] reset during compare");
    setCfg(1, 1, 3, 2, 4);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    cycles = 0;
    while (m_ph != P_COMP && cycles < 50) begin
      applyStimulus();
      cycles++;
    end
    checkOutput("reach_comp", 32'(m_ph == P_COMP), 32'd1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    repeat (25) applyStimulus();

    $display("[TB] start held high");
    setCfg(1, 1, 1, 1, 1);
    start = 1'b1;
    repeat (30) applyStimulus();
    start = 1'b0;
    repeat (5) applyStimulus();

    $display("[TB] randomised run");
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      cont  = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      setCfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)));
      setEnables(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 2'($urandom));
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
